pulse_seq_ctrl: RTL and testbench
=================================

// Module: pulse_seq_ctrl
// PURPOSE
//  Sequencing controller for the 16-bit loadable circular-shift pulse generator.
//  Accepts a pattern and rotation count on a start strobe and drives the generator's load_flag and parallel input.
//  Emits a gated pulse stream of exactly rotations*WIDTH bits, MSB first, then reports done.
//  Sits between the user/control logic and the generator instance; the generator itself stays unmodified.
// PARAMETERS
//  WIDTH  16  pattern width; must equal the generator width
//  CNT_W  8   width of rotation count (max 2^CNT_W-1 rotations)
// PORTS
//  clock       in   1      system clock, all state on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  start       in   1      request strobe, sampled when idle
//  pattern     in   WIDTH  pattern to emit; bit WIDTH-1 is sent first
//  rotations   in   CNT_W  number of full pattern passes; 0 = empty job
//  abort       in   1      cancel current job
//  gen_o       in   1      serial output of the generator
//  pg_pattern  out  WIDTH  generator parallel input (registered copy of pattern)
//  pg_load     out  1      generator load_flag
//  gate        out  1      high while gen_o carries valid job bits
//  pulse_out   out  1      gen_o & gate (combinational)
//  busy        out  1      job in progress
//  done        out  1      one-cycle completion pulse
//  pending     out  1      queued request held (0 unless PULSE_SEQ_QUEUE_EN)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including pg_pattern, counters and pending.
//  Reset is honoured in any state; a job in progress is dropped with no done.
//  FSM (Moore outputs decoded from the state register): IDLE, LOAD, PRIME, RUN, DONE.
//  IDLE: busy=0.
//   - start=1 and rotations!=0: capture pattern->pg_pattern and rotations; next state LOAD.
//   - start=1 and rotations==0: next state DONE; no load is issued.
//  LOAD: pg_load=1 for exactly 1 cycle; next state PRIME.
//  PRIME: 1 cycle, covering the generator's output-register latency.
//   - bit_cnt=0 and rot_cnt=0 on exit; next state RUN.
//  RUN: gate=1.
//   - bit_cnt counts 0..WIDTH-1 and wraps; rot_cnt increments on each wrap.
//   - Exit to DONE after the cycle with bit_cnt==WIDTH-1 and rot_cnt==rotations-1.
//   - RUN therefore lasts exactly rotations*WIDTH cycles.
//  DONE: done=1 for 1 cycle, busy=0; next state IDLE (see CONFIGURATION).
//  busy=1 in LOAD, PRIME and RUN only.
//  Alignment: first RUN cycle carries pattern[WIDTH-1], then descending bits.
//   - The sequence wraps to pattern[WIDTH-1] after pattern[0].
//  Latency: start sampled at edge 0 -> LOAD in cycle 1, PRIME in cycle 2, RUN from cycle 3.
//  abort=1 in LOAD, PRIME or RUN: next state IDLE; gate and pg_load go low next cycle.
//   - No done pulse; pending is cleared.
//   - abort in IDLE or DONE has no effect.
//  abort and start in the same cycle while IDLE: start wins.
//  start while not IDLE: ignored (see CONFIGURATION).
//  pg_pattern holds its value after a job ends; it is updated only on capture.
//  rotations at max (2^CNT_W-1): rot_cnt must not overflow the exit compare.
// CONFIGURATION
//  PULSE_SEQ_QUEUE_EN undefined: no request buffer; pending tied 0; start while busy is dropped.
//  PULSE_SEQ_QUEUE_EN defined: one-deep request slot.
//   - start in LOAD, PRIME, RUN or DONE with an empty slot: capture pattern and rotations, pending=1.
//   - start with the slot already full: dropped; the slot keeps its first request.
//   - In DONE with pending=1: slot moves to active registers, pending=0.
//     Next state is LOAD, or DONE again if the queued rotations==0.
//   - abort clears the slot.
// TESTING
//  T1 pattern=16'h8001, rotations=2, start at cycle 0:
//     pg_load=1 in cycle 1 only; gate=1 in cycles 3..34; pulse_out=1 in cycles 3, 18, 19, 34 only; done=1 in cycle 35.
//  T2 rotations=0, start:
//     done=1 in cycle 1; pg_load, gate and busy never assert.
//  T3 T1 job with abort=1 in cycle 10:
//     IDLE in cycle 11, gate=0 from cycle 11, no done; a new start in cycle 12 runs normally.
//  T4 reset_n low asynchronously mid-RUN (cycle 20):
//     all outputs 0 immediately; after release, start runs a clean job.
//  T5 (no macro) second start in cycle 5 during the T1 job:
//     ignored; single done at cycle 35; pending stays 0.
//  T6 (PULSE_SEQ_QUEUE_EN) second start in cycle 5 with pattern=16'hFFFF, rotations=1:
//     pending=1 from cycle 6; done in cycle 35; LOAD in cycle 36; gate in cycles 38..53; done in cycle 54.

Source files
------------

// File: rtl/pulse_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit loadable circular-shift pulse
// generator: loads the pattern, then gates exactly rotations*WIDTH bits.
// Ports: clock, reset_n, start, pattern, rotations, abort, gen_o in;
//        pg_pattern, pg_load, gate, pulse_out, busy, done, pending out.
// Option: define PULSE_SEQ_QUEUE_EN for a one-deep request slot.
`timescale 1ns/1ps
module pulse_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] rotations,
  input  logic             abort,
  input  logic             gen_o,
  output logic [WIDTH-1:0] pg_pattern,
  output logic             pg_load,
  output logic             gate,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             pending
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRIME, S_RUN, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] rot_reg, rot_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             bit_last, rot_last;
  logic             ld_in;

  assign bit_last = bit_cnt == BW'(WIDTH-1);
  // rot_reg is never 0 while in RUN, so the -1 cannot wrap
  assign rot_last = rot_cnt == rot_reg - CNT_W'(1);

  assign pg_load   = state == S_LOAD;
  assign gate      = state == S_RUN;
  assign done      = state == S_DONE;
  assign busy      = pg_load | gate | (state == S_PRIME);
  assign pulse_out = gen_o & gate;

`ifdef PULSE_SEQ_QUEUE_EN
  logic [WIDTH-1:0] q_pat;
  logic [CNT_W-1:0] q_rot;
  logic             ld_q, q_set, q_clr;
`endif

  always_comb begin
    state_nx = state;
    ld_in    = 1'b0;
`ifdef PULSE_SEQ_QUEUE_EN
    ld_q  = 1'b0;
    q_set = 1'b0;
    q_clr = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
`ifdef PULSE_SEQ_QUEUE_EN
        if (pending) begin
          ld_q     = q_rot != '0;
          q_clr    = 1'b1;
          state_nx = (q_rot != '0) ? S_LOAD : S_DONE;
        end else
`endif
        if (start) begin
          ld_in    = rotations != '0;
          state_nx = (rotations != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD:  state_nx = abort ? S_IDLE : S_PRIME;
      S_PRIME: state_nx = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)
          state_nx = S_IDLE;
        else if (bit_last && rot_last)
          state_nx = S_DONE;
      end
      S_DONE: begin
`ifdef PULSE_SEQ_QUEUE_EN
        if (pending) begin
          ld_q     = q_rot != '0;
          q_clr    = 1'b1;
          state_nx = (q_rot != '0) ? S_LOAD : S_DONE;
        end else
`endif
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
`ifdef PULSE_SEQ_QUEUE_EN
    if (start && !pending && state != S_IDLE)
      q_set = 1'b1;
    if (abort && busy) begin
      q_set = 1'b0;
      q_clr = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pg_pattern <= '0;
      rot_reg    <= '0;
    end else if (ld_in) begin
      pg_pattern <= pattern;
      rot_reg    <= rotations;
    end
`ifdef PULSE_SEQ_QUEUE_EN
    else if (ld_q) begin
      pg_pattern <= q_pat;
      rot_reg    <= q_rot;
    end
`endif
  end

  // bit_cnt/rot_cnt are cleared in PRIME so RUN starts at 0/0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      rot_cnt <= '0;
    end else if (state == S_PRIME) begin
      bit_cnt <= '0;
      rot_cnt <= '0;
    end else if (state == S_RUN) begin
      if (bit_last) begin
        bit_cnt <= '0;
        rot_cnt <= rot_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

`ifdef PULSE_SEQ_QUEUE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      q_pat   <= '0;
      q_rot   <= '0;
    end else if (q_clr) begin
      pending <= 1'b0;
    end else if (q_set) begin
      pending <= 1'b1;
      q_pat   <= pattern;
      q_rot   <= rotations;
    end
  end
`else
  assign pending = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl with a behavioural
// circular-shift generator model attached to pg_pattern/pg_load.
`timescale 1ns/1ps
module tb_pulse_seq_ctrl;
  localparam int W = 16;
  localparam int C = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [C-1:0] rotations = '0;
  logic         gen_o;
  logic [W-1:0] pg_pattern;
  logic         pg_load, gate, pulse_out;
  logic         busy, done, pending;

  pulse_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .pattern(pattern), .rotations(rotations), .abort(abort),
    .gen_o(gen_o), .pg_pattern(pg_pattern), .pg_load(pg_load),
    .gate(gate), .pulse_out(pulse_out), .busy(busy),
    .done(done), .pending(pending)
  );

  always #5 clock = ~clock;

  // generator: load, rotate left, output register on the MSB
  logic [W-1:0] sr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr    <= '0;
      gen_o <= 1'b0;
    end else if (pg_load) begin
      sr <= pg_pattern;
    end else begin
      sr    <= {sr[W-2:0], sr[W-1]};
      gen_o <= sr[W-1];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {40'd0, pg_pattern, pg_load, gate, pulse_out,
            busy, done, pending};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    repeat (2) tick();
    chk("reset_outs", outs(), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [15:0] pat;
    int          rot;
    int          ab;
    int          e_done;
    int          e_ones;
    int          e_gate;
    logic [63:0] e_mask;
    int          e_loads;
    logic [15:0] e_pgp;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v, input int id);
    int done_at, ones, gates, loads, dcnt, len;
    logic [63:0] mask;
    string s;
    done_at = -1; ones = 0; gates = 0; loads = 0; dcnt = 0;
    mask = '0;
    len = 16 * v.rot + 10;
    pattern   = v.pat;
    rotations = C'(v.rot);
    start     = 1'b1;
    abort     = 1'b0;
    for (int r = 1; r <= len; r++) begin
      tick();
      start = 1'b0;
      abort = (r == v.ab);
      if (pg_load) loads++;
      if (gate) gates++;
      if (pulse_out) begin
        ones++;
        if (r < 64) mask[r] = 1'b1;
      end
      if (done) begin
        dcnt++;
        done_at = r;
      end
    end
    abort = 1'b0;
    s = $sformatf("v%0d", id);
    chk({s, "_done_at"}, done_at, v.e_done);
    chk({s, "_done_cnt"}, dcnt, (v.e_done >= 0) ? 1 : 0);
    chk({s, "_ones"}, ones, v.e_ones);
    chk({s, "_gates"}, gates, v.e_gate);
    chk({s, "_mask"}, mask, v.e_mask);
    chk({s, "_loads"}, loads, v.e_loads);
    chk({s, "_pgp"}, pg_pattern, v.e_pgp);
    chk({s, "_idle"}, {busy, gate, pending}, 3'b000);
  endtask

  initial begin
    int dcnt, d1, d2, loads, lastld, gates, lastg;
    logic pend6;
    int jc, jr, ab, idle_from;
    bit have;
    logic [15:0] jp, mpgp, pt;
    logic e_ld, e_gt, e_bz, e_dn, e_pl, st, ab_in;
    int rr;

    vt[0] = '{16'h8001, 2, -1, 35, 4, 32,
              64'h0000_0004_000C_0008, 1, 16'h8001};
    vt[1] = '{16'h1234, 0, -1, 1, 0, 0, 64'h0, 0, 16'h8001};
    vt[2] = '{16'h8001, 2, 10, -1, 1, 8, 64'h8, 1, 16'h8001};
    vt[3] = '{16'hFFFF, 1, -1, 19, 16, 16, 64'h7FFF8, 1, 16'hFFFF};
    vt[4] = '{16'h4000, 3, -1, 51, 3, 48,
              64'h0000_0010_0010_0010, 1, 16'h4000};
    vt[5] = '{16'h0001, 255, -1, 4083, 255, 4080,
              64'h0004_0004_0004_0000, 1, 16'h0001};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // asynchronous reset in the middle of RUN
    pattern = 16'h8001; rotations = 8'd2; start = 1'b1;
    for (int r = 1; r <= 20; r++) begin
      tick();
      start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outs", outs(), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    run_vec(vt[0], 10);

    // second start during a running job
    dcnt = 0; d1 = -1; d2 = -1; loads = 0; lastld = -1;
    gates = 0; lastg = -1; pend6 = 1'b0;
    pattern = 16'h8001; rotations = 8'd2; start = 1'b1;
    for (int r = 1; r <= 70; r++) begin
      tick();
      start = (r == 5);
      if (r == 5) begin
        pattern = 16'hFFFF;
        rotations = 8'd1;
      end
      if (r == 6) pend6 = pending;
      if (pg_load) begin loads++; lastld = r; end
      if (gate) begin gates++; lastg = r; end
      if (done) begin
        dcnt++;
        if (d1 < 0) d1 = r;
        d2 = r;
      end
    end
    chk("t56_first_done", d1, 35);
`ifdef PULSE_SEQ_QUEUE_EN
    chk("t6_pend6", pend6, 1'b1);
    chk("t6_dcnt", dcnt, 2);
    chk("t6_second_done", d2, 54);
    chk("t6_loads", loads, 2);
    chk("t6_last_load", lastld, 36);
    chk("t6_gates", gates, 48);
    chk("t6_last_gate", lastg, 53);
    chk("t6_pgp", pg_pattern, 16'hFFFF);
`else
    chk("t5_pend6", pend6, 1'b0);
    chk("t5_dcnt", dcnt, 1);
    chk("t5_loads", loads, 1);
    chk("t5_last_load", lastld, 1);
    chk("t5_gates", gates, 32);
    chk("t5_last_gate", lastg, 34);
    chk("t5_pgp", pg_pattern, 16'h8001);
`endif

`ifndef PULSE_SEQ_QUEUE_EN
    // random jobs against a timeline model of each accepted job
    do_reset();
    have = 1'b0; jc = 0; jr = 0; ab = 0; jp = '0;
    mpgp = '0; idle_from = 0;
    for (int k = 0; k < 3000; k++) begin
      e_ld = 0; e_gt = 0; e_bz = 0; e_dn = 0; e_pl = 0;
      if (have && k <= ab) begin
        if (jr == 0) begin
          e_dn = (k == jc + 1);
        end else begin
          e_ld = (k == jc + 1);
          e_bz = (k >= jc + 1) && (k <= jc + 2 + 16 * jr);
          e_gt = (k >= jc + 3) && (k <= jc + 2 + 16 * jr);
          e_dn = (k == jc + 3 + 16 * jr);
          if (e_gt) e_pl = jp[15 - ((k - jc - 3) % 16)];
        end
      end
      chk($sformatf("rnd_ctl_c%0d", k),
          {pg_load, gate, pulse_out, busy, done, pending},
          {e_ld, e_gt, e_pl, e_bz, e_dn, 1'b0});
      chk($sformatf("rnd_pgp_c%0d", k), pg_pattern, mpgp);
      st    = ($urandom % 4) == 0;
      ab_in = ($urandom % 30) == 0;
      pt    = 16'($urandom);
      rr    = (($urandom % 16) == 0) ? 37 : int'($urandom_range(0, 5));
      if (st && k >= idle_from) begin
        have = 1'b1; jc = k; jr = rr; jp = pt; ab = 1 << 30;
        if (rr != 0) mpgp = pt;
        idle_from = (rr != 0) ? k + 4 + 16 * rr : k + 2;
      end else if (ab_in && have && jr != 0 && k <= ab &&
                   k >= jc + 1 && k <= jc + 2 + 16 * jr) begin
        ab = k;
        idle_from = k + 1;
      end
      start = st; pattern = pt; rotations = C'(rr); abort = ab_in;
      tick();
    end
    start = 1'b0; abort = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
